// File: rtl/instr_receive_pkg.sv
// Definitions shared by the instruction receiver and its transmitter peer:
// receiver state encodings and the default instruction word width.
package instr_receive_pkg;

    localparam int IWIDTH_DEF = 32;

    typedef enum logic [1:0] {
        RX_IDLE = 2'd0,
        RX_LOAD = 2'd1,
        RX_DONE = 2'd2
    } rx_state_t;

endpackage

// File: rtl/instr_receive_rx_buf.sv
// DEPTH x IWIDTH instruction buffer: synchronous write port, registered read
// port that returns zero for entries at or beyond the current word count.
module rx_buf
    import instr_receive_pkg::*;
#(
    parameter int IWIDTH = IWIDTH_DEF,
    parameter int DEPTH  = 2,
    parameter int AWIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int CWIDTH = $clog2(DEPTH + 1)
) (
    input  logic              r_clk,
    input  logic              r_rst,
    input  logic              we,
    input  logic [AWIDTH-1:0] waddr,
    input  logic [IWIDTH-1:0] wdata,
    input  logic              rd,
    input  logic [AWIDTH-1:0] raddr,
    input  logic [CWIDTH-1:0] count,
    output logic [IWIDTH-1:0] rdata,
    output logic              rvalid
);

    logic [IWIDTH-1:0] mem [DEPTH];
    logic [IWIDTH-1:0] rdata_p0;
    logic              vld_p0;
    logic              rd_in_range;

    // Contents are never cleared; the count alone says which entries are live.
    always_ff @(posedge r_clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        rd_in_range = 1'b0;
        if ((CWIDTH'(raddr) < count) && (int'(raddr) < DEPTH)) begin
            rd_in_range = 1'b1;
        end
    end

    // Read stage: one-cycle registered output, old contents on a same-cycle write.
    always_ff @(posedge r_clk) begin
        if (!r_rst) begin
            rdata_p0 <= '0;
            vld_p0   <= 1'b0;
        end else begin
            vld_p0 <= rd;
            if (rd) begin
                rdata_p0 <= rd_in_range ? mem[raddr] : '0;
            end
        end
    end

    assign rdata  = rdata_p0;
    assign rvalid = vld_p0;

endmodule

// File: rtl/instr_receive.sv
// Instruction receiver: requests a load from the transmitter, captures acked
// words until 'last' or overflow, then exposes them through rx_buf.
module instr_receive
    import instr_receive_pkg::*;
#(
    parameter int IWIDTH = IWIDTH_DEF,
    parameter int DEPTH  = 2,
    parameter int AWIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int CWIDTH = $clog2(DEPTH + 1)
) (
    input  logic              r_clk,
    input  logic              r_rst,
    input  logic              r_i_start,
    output logic              r_o_syn,
    input  logic [IWIDTH-1:0] r_i_instr,
    input  logic              r_i_last,
    input  logic              r_i_ack,
    input  logic              r_i_rd,
    input  logic [AWIDTH-1:0] r_i_raddr,
    output logic [IWIDTH-1:0] r_o_rdata,
    output logic              r_o_rvalid,
    output logic [CWIDTH-1:0] r_o_count,
    output logic              r_o_done,
    output logic              r_o_err
);

    rx_state_t         state_q, state_d;
    logic [CWIDTH-1:0] count_q, count_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              syn_q;
    logic              we;

    always_ff @(posedge r_clk) begin
        if (!r_rst) begin
            state_q <= RX_IDLE;
            count_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            syn_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            done_q  <= done_d;
            err_q   <= err_d;
            syn_q   <= (state_d == RX_LOAD);
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        done_d  = done_q;
        err_d   = err_q;
        we      = 1'b0;
        unique case (state_q)
            RX_IDLE, RX_DONE: begin
                if (r_i_start) begin
                    state_d = RX_LOAD;
                    count_d = '0;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                end
            end
            RX_LOAD: begin
                if (r_i_ack) begin
                    // A full buffer drops the word even if it is flagged last.
                    if (count_q == CWIDTH'(DEPTH)) begin
                        err_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = RX_DONE;
                    end else begin
                        we      = 1'b1;
                        count_d = count_q + 1'b1;
                        if (r_i_last) begin
                            done_d  = 1'b1;
                            state_d = RX_DONE;
                        end
                    end
                end
            end
            default: begin
                state_d = RX_IDLE;
            end
        endcase
    end

    rx_buf #(
        .IWIDTH (IWIDTH),
        .DEPTH  (DEPTH),
        .AWIDTH (AWIDTH),
        .CWIDTH (CWIDTH)
    ) u_rx_buf (
        .r_clk  (r_clk),
        .r_rst  (r_rst),
        .we     (we),
        .waddr  (AWIDTH'(count_q)),
        .wdata  (r_i_instr),
        .rd     (r_i_rd),
        .raddr  (r_i_raddr),
        .count  (count_q),
        .rdata  (r_o_rdata),
        .rvalid (r_o_rvalid)
    );

    assign r_o_syn   = syn_q;
    assign r_o_count = count_q;
    assign r_o_done  = done_q;
    assign r_o_err   = err_q;

endmodule

// File: tb/tb_instr_receive.sv
// Bench for instr_receive: directed load scenarios with literal expectations,
// then random traffic compared every cycle against a behavioural model.
module tb_instr_receive;

    localparam int IWIDTH = 32;
    localparam int DEPTH  = 2;
    localparam int AWIDTH = 1;
    localparam int CWIDTH = 2;

    logic              r_clk = 1'b0;
    logic              r_rst;
    logic              r_i_start;
    logic              r_o_syn;
    logic [IWIDTH-1:0] r_i_instr;
    logic              r_i_last;
    logic              r_i_ack;
    logic              r_i_rd;
    logic [AWIDTH-1:0] r_i_raddr;
    logic [IWIDTH-1:0] r_o_rdata;
    logic              r_o_rvalid;
    logic [CWIDTH-1:0] r_o_count;
    logic              r_o_done;
    logic              r_o_err;

    int checks = 0;
    int errors = 0;

    instr_receive #(
        .IWIDTH (IWIDTH),
        .DEPTH  (DEPTH),
        .AWIDTH (AWIDTH),
        .CWIDTH (CWIDTH)
    ) dut (
        .r_clk      (r_clk),
        .r_rst      (r_rst),
        .r_i_start  (r_i_start),
        .r_o_syn    (r_o_syn),
        .r_i_instr  (r_i_instr),
        .r_i_last   (r_i_last),
        .r_i_ack    (r_i_ack),
        .r_i_rd     (r_i_rd),
        .r_i_raddr  (r_i_raddr),
        .r_o_rdata  (r_o_rdata),
        .r_o_rvalid (r_o_rvalid),
        .r_o_count  (r_o_count),
        .r_o_done   (r_o_done),
        .r_o_err    (r_o_err)
    );

    always #5 r_clk = ~r_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a loading flag, a word count, and an array of words.
    bit          m_loading = 0;
    int          m_count   = 0;
    bit          m_done    = 0;
    bit          m_err     = 0;
    bit          m_syn     = 0;
    bit          m_rvalid  = 0;
    logic [31:0] m_rdata   = '0;
    logic [31:0] m_mem [DEPTH];
    bit          m_armed   = 0;

    always @(posedge r_clk) begin
        if (!r_rst) begin
            m_loading = 0; m_count = 0; m_done = 0; m_err = 0;
            m_syn = 0; m_rvalid = 0; m_rdata = '0; m_armed = 1;
        end else begin
            m_rvalid = r_i_rd;
            if (r_i_rd)
                m_rdata = (int'(r_i_raddr) < m_count) ? m_mem[r_i_raddr] : '0;
            if (!m_loading) begin
                if (r_i_start) begin
                    m_loading = 1; m_count = 0; m_done = 0; m_err = 0;
                end
            end else if (r_i_ack) begin
                if (m_count == DEPTH) begin
                    m_err = 1; m_done = 1; m_loading = 0;
                end else begin
                    m_mem[m_count] = r_i_instr;
                    m_count++;
                    if (r_i_last) begin
                        m_done = 1; m_loading = 0;
                    end
                end
            end
            m_syn = m_loading;
        end
    end

    always @(negedge r_clk) begin
        if (m_armed) begin
            check("syn", 32'(r_o_syn), 32'(m_syn));
            check("done", 32'(r_o_done), 32'(m_done));
            check("err", 32'(r_o_err), 32'(m_err));
            check("count", 32'(r_o_count), 32'(m_count));
            check("rvalid", 32'(r_o_rvalid), 32'(m_rvalid));
            if (m_rvalid) check("rdata", r_o_rdata, m_rdata);
        end
    end

    task automatic tick();
        @(posedge r_clk);
        #1;
    endtask

    task automatic ack_word(input logic [31:0] w, input logic last);
        r_i_ack = 1'b1; r_i_instr = w; r_i_last = last;
        tick();
        r_i_ack = 1'b0; r_i_last = 1'b0;
    endtask

    task automatic read_word(input logic [AWIDTH-1:0] a, input logic [31:0] exp, input string name);
        r_i_rd = 1'b1; r_i_raddr = a;
        tick();
        r_i_rd = 1'b0;
        check({name, "_rvalid"}, 32'(r_o_rvalid), 32'd1);
        check({name, "_rdata"}, r_o_rdata, exp);
    endtask

    task automatic pulse_start();
        r_i_start = 1'b1;
        tick();
        r_i_start = 1'b0;
    endtask

    initial begin
        r_rst = 1'b0; r_i_start = 1'b0; r_i_instr = 32'hDEADBEEF;
        r_i_last = 1'b0; r_i_ack = 1'b1; r_i_rd = 1'b0; r_i_raddr = '0;
        tick(); tick();
        r_rst = 1'b1; r_i_ack = 1'b0;
        check("rst_count", 32'(r_o_count), 32'd0);
        check("rst_syn", 32'(r_o_syn), 32'd0);
        check("rst_done", 32'(r_o_done), 32'd0);
        check("rst_err", 32'(r_o_err), 32'd0);
        check("rst_rvalid", 32'(r_o_rvalid), 32'd0);
        check("rst_rdata", r_o_rdata, 32'd0);

        // Normal two-word load.
        pulse_start();
        check("norm_syn_up", 32'(r_o_syn), 32'd1);
        ack_word(32'h20080005, 1'b0);
        check("norm_syn_mid", 32'(r_o_syn), 32'd1);
        ack_word(32'h2009000A, 1'b1);
        check("norm_count", 32'(r_o_count), 32'd2);
        check("norm_done", 32'(r_o_done), 32'd1);
        check("norm_err", 32'(r_o_err), 32'd0);
        check("norm_syn_down", 32'(r_o_syn), 32'd0);
        read_word(1'b0, 32'h20080005, "norm_rd0");
        read_word(1'b1, 32'h2009000A, "norm_rd1");

        // Overflow: third word is dropped.
        pulse_start();
        ack_word(32'h11111111, 1'b0);
        ack_word(32'h22222222, 1'b0);
        ack_word(32'h33333333, 1'b0);
        check("ovf_count", 32'(r_o_count), 32'd2);
        check("ovf_err", 32'(r_o_err), 32'd1);
        check("ovf_done", 32'(r_o_done), 32'd1);
        check("ovf_syn", 32'(r_o_syn), 32'd0);
        read_word(1'b1, 32'h22222222, "ovf_rd1");
        ack_word(32'h44444444, 1'b0);
        check("done_ack_count", 32'(r_o_count), 32'd2);

        // Ack in IDLE, start mid-load, out-of-range read.
        r_rst = 1'b0; tick(); r_rst = 1'b1;
        ack_word(32'h55555555, 1'b1);
        check("idle_ack_count", 32'(r_o_count), 32'd0);
        pulse_start();
        ack_word(32'hABCD0001, 1'b0);
        pulse_start();
        check("restart_load_count", 32'(r_o_count), 32'd1);
        check("restart_load_syn", 32'(r_o_syn), 32'd1);
        read_word(1'b1, 32'h0, "oor_rd1");
        read_word(1'b0, 32'hABCD0001, "load_rd0");

        // Reset mid-load, then a clean load.
        r_rst = 1'b0; tick(); r_rst = 1'b1;
        check("midrst_count", 32'(r_o_count), 32'd0);
        check("midrst_syn", 32'(r_o_syn), 32'd0);
        pulse_start();
        ack_word(32'h0000AAAA, 1'b0);
        ack_word(32'h0000BBBB, 1'b1);
        check("post_rst_done", 32'(r_o_done), 32'd1);
        check("post_rst_count", 32'(r_o_count), 32'd2);

        // Restart from DONE overwrites the buffer.
        pulse_start();
        check("redo_done", 32'(r_o_done), 32'd0);
        check("redo_count", 32'(r_o_count), 32'd0);
        ack_word(32'hC0DE0000, 1'b0);
        ack_word(32'hC0DE0001, 1'b1);
        read_word(1'b0, 32'hC0DE0000, "redo_rd0");
        read_word(1'b1, 32'hC0DE0001, "redo_rd1");

        // Random traffic, checked by the model every cycle.
        for (int i = 0; i < 3000; i++) begin
            r_rst     = ($urandom_range(0, 63) != 0);
            r_i_start = ($urandom_range(0, 7) == 0);
            r_i_ack   = ($urandom_range(0, 1) == 1);
            r_i_last  = ($urandom_range(0, 3) == 0);
            r_i_instr = $urandom;
            r_i_rd    = ($urandom_range(0, 1) == 1);
            r_i_raddr = AWIDTH'($urandom_range(0, 1));
            tick();
        end
        r_rst = 1'b1; r_i_start = 1'b0; r_i_ack = 1'b0; r_i_rd = 1'b0;
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
